// File: rtl/ahb_master_arbiter.sv
// Round-robin arbiter multiplexing several AHB3-Lite masters onto one shared bus.
// Ownership changes only at a burst boundary: the owner is IDLE and HREADY is high.
module ahb_master_arbiter #(
  parameter int unsigned MASTERS = 2
) (
  input  logic                 s_clk_i,
  input  logic                 s_resetn_i,
  input  logic [31:0]          s_mhaddr_i  [MASTERS],
  input  logic [1:0]           s_mhtrans_i [MASTERS],
  input  logic                 s_mhwrite_i [MASTERS],
  input  logic [2:0]           s_mhsize_i  [MASTERS],
  input  logic [2:0]           s_mhburst_i [MASTERS],
  input  logic [31:0]          s_mhwdata_i [MASTERS],
  output logic [31:0]          s_hhaddr_o,
  output logic [1:0]           s_hhtrans_o,
  output logic                 s_hhwrite_o,
  output logic [2:0]           s_hhsize_o,
  output logic [2:0]           s_hhburst_o,
  output logic [31:0]          s_hhwdata_o,
  input  logic                 s_hready_i,
  input  logic                 s_hresp_i,
  input  logic [31:0]          s_hrdata_i,
  output logic                 s_mhready_o [MASTERS],
  output logic                 s_mhresp_o  [MASTERS],
  output logic [31:0]          s_mhrdata_o,
  output logic [MASTERS-1:0]   s_grant_o
);

  localparam int unsigned OW = (MASTERS > 1) ? $clog2(MASTERS) : 1;

  typedef enum logic {
    ST_PARK  = 1'b0,
    ST_OWNED = 1'b1
  } state_t;

  state_t          r_owned, nxt_owned;
  logic [OW-1:0]   r_owner, nxt_owner;
  logic [OW-1:0]   r_rr_ptr, nxt_rr_ptr;

  logic [MASTERS-1:0] req;
  logic [31:0]     own_haddr;
  logic [1:0]      own_htrans;
  logic            own_hwrite;
  logic [2:0]      own_hsize;
  logic [2:0]      own_hburst;
  logic [31:0]     own_hwdata;
  logic            rr_found;
  logic [OW-1:0]   rr_win;
  logic [OW-1:0]   rr_win_inc;

  // A master requests while it presents NONSEQ or SEQ
  always_comb begin
    req = '0;
    for (int unsigned m = 0; m < MASTERS; m++) begin
      req[m] = s_mhtrans_i[m][1];
    end
  end

  // Current owner's address/control/data selection
  always_comb begin
    own_haddr  = '0;
    own_htrans = '0;
    own_hwrite = 1'b0;
    own_hsize  = '0;
    own_hburst = '0;
    own_hwdata = '0;
    for (int unsigned m = 0; m < MASTERS; m++) begin
      if (r_owner == OW'(m)) begin
        own_haddr  = s_mhaddr_i[m];
        own_htrans = s_mhtrans_i[m];
        own_hwrite = s_mhwrite_i[m];
        own_hsize  = s_mhsize_i[m];
        own_hburst = s_mhburst_i[m];
        own_hwdata = s_mhwdata_i[m];
      end
    end
  end

  // Cyclic search from r_rr_ptr; the owner never competes against itself
  always_comb begin
    int unsigned   idx;
    logic [OW-1:0] idx_w;
    rr_found = 1'b0;
    rr_win   = r_rr_ptr;
    idx      = 0;
    idx_w    = '0;
    for (int unsigned i = 0; i < MASTERS; i++) begin
      idx = 32'(r_rr_ptr) + i;
      if (idx >= MASTERS) begin
        idx = idx - MASTERS;
      end
      idx_w = OW'(idx);
      if (!rr_found && req[idx_w] &&
          !((r_owned == ST_OWNED) && (idx_w == r_owner))) begin
        rr_found = 1'b1;
        rr_win   = idx_w;
      end
    end
    rr_win_inc = (32'(rr_win) == (MASTERS - 1)) ? '0 : rr_win + OW'(1);
  end

  always_ff @(posedge s_clk_i or negedge s_resetn_i) begin
    if (!s_resetn_i) begin
      r_owned  <= ST_PARK;
      r_owner  <= '0;
      r_rr_ptr <= '0;
    end else begin
      r_owned  <= nxt_owned;
      r_owner  <= nxt_owner;
      r_rr_ptr <= nxt_rr_ptr;
    end
  end

  always_comb begin
    nxt_owned  = r_owned;
    nxt_owner  = r_owner;
    nxt_rr_ptr = r_rr_ptr;
    case (r_owned)
      ST_PARK: begin
        if (rr_found) begin
          nxt_owned  = ST_OWNED;
          nxt_owner  = rr_win;
          nxt_rr_ptr = rr_win_inc;
        end
      end
      ST_OWNED: begin
        // BUSY/NONSEQ/SEQ keep the bus so bursts stay intact
        if (s_hready_i && (own_htrans == 2'b00) && rr_found) begin
          nxt_owner  = rr_win;
          nxt_rr_ptr = rr_win_inc;
        end
      end
      default: begin
        nxt_owned = ST_PARK;
      end
    endcase
  end

  // Shared bus drive and per-master response routing
  always_comb begin
    s_hhaddr_o  = '0;
    s_hhtrans_o = '0;
    s_hhwrite_o = 1'b0;
    s_hhsize_o  = '0;
    s_hhburst_o = '0;
    s_hhwdata_o = '0;
    s_grant_o   = '0;
    if (r_owned == ST_OWNED) begin
      s_hhaddr_o  = own_haddr;
      s_hhtrans_o = own_htrans;
      s_hhwrite_o = own_hwrite;
      s_hhsize_o  = own_hsize;
      s_hhburst_o = own_hburst;
      s_hhwdata_o = own_hwdata;
    end
    for (int unsigned m = 0; m < MASTERS; m++) begin
      s_mhready_o[m] = !req[m];
      s_mhresp_o[m]  = 1'b0;
      if ((r_owned == ST_OWNED) && (r_owner == OW'(m))) begin
        s_grant_o[m]   = 1'b1;
        s_mhready_o[m] = s_hready_i;
        s_mhresp_o[m]  = s_hresp_i;
      end
    end
  end

  assign s_mhrdata_o = s_hrdata_i;

endmodule

// File: tb/tb_ahb_master_arbiter.sv
// Directed plus randomized bench for ahb_master_arbiter (three masters) against an ownership model.
module tb_ahb_master_arbiter;

  localparam int N = 3;

  logic        clk = 1'b0;
  logic        resetn;
  logic [31:0] maddr  [N];
  logic [1:0]  mtrans [N];
  logic        mwrite [N];
  logic [2:0]  msize  [N];
  logic [2:0]  mburst [N];
  logic [31:0] mwdata [N];
  logic [31:0] haddr, hwdata, hrdata, mrdata;
  logic [1:0]  htrans;
  logic        hwrite, hready, hresp;
  logic [2:0]  hsize, hburst;
  logic        mready [N];
  logic        mresp  [N];
  logic [N-1:0] grant;

  int n_cmp = 0;
  int n_bad = 0;
  int m_owner;   // -1 when parked
  int m_ptr;

  always #5 clk = ~clk;

  ahb_master_arbiter #(.MASTERS(N)) dut (
    .s_clk_i(clk), .s_resetn_i(resetn),
    .s_mhaddr_i(maddr), .s_mhtrans_i(mtrans), .s_mhwrite_i(mwrite),
    .s_mhsize_i(msize), .s_mhburst_i(mburst), .s_mhwdata_i(mwdata),
    .s_hhaddr_o(haddr), .s_hhtrans_o(htrans), .s_hhwrite_o(hwrite),
    .s_hhsize_o(hsize), .s_hhburst_o(hburst), .s_hhwdata_o(hwdata),
    .s_hready_i(hready), .s_hresp_i(hresp), .s_hrdata_i(hrdata),
    .s_mhready_o(mready), .s_mhresp_o(mresp), .s_mhrdata_o(mrdata),
    .s_grant_o(grant)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Winner = requester with the smallest cyclic distance from the pointer
  function automatic int rr_pick(input int excl);
    int best, bestd, d;
    best = -1;
    bestd = N;
    for (int m = 0; m < N; m++) begin
      if (mtrans[m][1] && m != excl) begin
        d = (m - m_ptr + N) % N;
        if (d < bestd) begin
          bestd = d;
          best = m;
        end
      end
    end
    return best;
  endfunction

  task automatic check_all(input string tag);
    logic [N-1:0] eg, er, es, og, orr, os;
    for (int m = 0; m < N; m++) begin
      eg[m]  = (m_owner == m);
      er[m]  = (m_owner == m) ? hready : !mtrans[m][1];
      es[m]  = (m_owner == m) ? hresp : 1'b0;
      orr[m] = mready[m];
      os[m]  = mresp[m];
    end
    og = grant;
    chk({tag, "_grant"}, 64'(og), 64'(eg));
    chk({tag, "_mready"}, 64'(orr), 64'(er));
    chk({tag, "_mresp"}, 64'(os), 64'(es));
    chk({tag, "_mrdata"}, 64'(mrdata), 64'(hrdata));
    if (m_owner < 0) begin
      chk({tag, "_bus_park"}, {haddr, hwdata}, 64'd0);
      chk({tag, "_ctl_park"}, 64'({htrans, hwrite, hsize, hburst}), 64'd0);
    end else begin
      chk({tag, "_addr_data"}, {haddr, hwdata}, {maddr[m_owner], mwdata[m_owner]});
      chk({tag, "_ctl"}, 64'({htrans, hwrite, hsize, hburst}),
          64'({mtrans[m_owner], mwrite[m_owner], msize[m_owner], mburst[m_owner]}));
    end
  endtask

  // One clock: check at the falling edge, advance the model across the rising edge
  task automatic cyc(input string tag);
    int no, np, w;
    @(negedge clk);
    check_all(tag);
    no = m_owner;
    np = m_ptr;
    if (!resetn) begin
      no = -1;
      np = 0;
    end else if (m_owner < 0) begin
      w = rr_pick(-1);
      if (w >= 0) begin no = w; np = (w + 1) % N; end
    end else if (hready && mtrans[m_owner] == 2'b00) begin
      w = rr_pick(m_owner);
      if (w >= 0) begin no = w; np = (w + 1) % N; end
    end
    @(posedge clk);
    m_owner = no;
    m_ptr = np;
    #1;
  endtask

  task automatic set_m(input int m, input logic [31:0] a, input logic [1:0] t);
    maddr[m]  = a;
    mtrans[m] = t;
    mwrite[m] = 1'($urandom);
    msize[m]  = 3'($urandom);
    mburst[m] = 3'($urandom);
    mwdata[m] = $urandom;
  endtask

  task automatic apply_reset(input string tag);
    resetn = 1'b0;
    #1;
    m_owner = -1;
    m_ptr = 0;
    chk({tag, "_async_grant"}, 64'(grant), 64'd0);
    chk({tag, "_async_htrans"}, 64'(htrans), 64'd0);
  endtask

  int order [4] = '{0, 1, 2, 0};

  initial begin
    for (int m = 0; m < N; m++) set_m(m, 32'h0, 2'b00);
    hready = 1'b1;
    hresp  = 1'b0;
    hrdata = 32'hA5A5_0001;
    resetn = 1'b0;
    m_owner = -1;
    m_ptr = 0;
    repeat (2) @(posedge clk);
    #1;

    // Grant one cycle after reset release
    set_m(0, 32'h1000, 2'd2);
    cyc("rst_hold");
    chk("rst_grant", 64'(grant), 64'd0);
    resetn = 1'b1;
    cyc("park_m0");
    chk("first_grant", 64'(grant), 64'b001);
    chk("first_haddr", 64'(haddr), 64'h1000);
    chk("first_htrans", 64'(htrans), 64'd2);
    set_m(0, 32'h0, 2'd0);
    cyc("m0_idle_keep");
    chk("park_on_last", 64'(grant), 64'b001);

    // Simultaneous requests from PARK
    apply_reset("b");
    set_m(0, 32'h1000, 2'd2);
    set_m(1, 32'h2000, 2'd2);
    cyc("b_rst");
    resetn = 1'b1;
    cyc("b_park");
    chk("b_grant_m0", 64'(grant), 64'b001);
    chk("b_m1_wait", 64'(mready[1]), 64'd0);
    set_m(0, 32'h0, 2'd0);
    cyc("b_handoff");
    chk("b_grant_m1", 64'(grant), 64'b010);
    chk("b_haddr_m1", 64'(haddr), 64'h2000);

    // Burst (including BUSY) is never split
    apply_reset("c");
    set_m(0, 32'h4000, 2'd2);
    set_m(1, 32'h3000, 2'd2);
    set_m(2, 32'h0, 2'd0);
    cyc("c_rst");
    resetn = 1'b1;
    cyc("c_park");
    chk("c_grant_nonseq", 64'(grant), 64'b001);
    for (int k = 0; k < 4; k++) begin
      set_m(0, 32'h4000 + 32'(4 * k), (k == 0) ? 2'd1 : 2'd3);
      cyc("c_beat");
      chk("c_grant_beat", 64'(grant), 64'b001);
      chk("c_m1_held", 64'(mready[1]), 64'd0);
    end
    set_m(0, 32'h0, 2'd0);
    cyc("c_end");
    chk("c_grant_m1", 64'(grant), 64'b010);

    // Wait states delay the handoff
    set_m(0, 32'h5000, 2'd2);
    set_m(1, 32'h0, 2'd0);
    hready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      cyc("d_wait");
      chk("d_grant_hold", 64'(grant), 64'b010);
    end
    hready = 1'b1;
    cyc("d_ready");
    chk("d_grant_m0", 64'(grant), 64'b001);

    // Two-cycle ERROR response
    set_m(1, 32'h6000, 2'd2);
    set_m(0, 32'h0, 2'd0);
    hresp = 1'b1;
    hready = 1'b0;
    #1;
    chk("e_mresp_owner", 64'(mresp[0]), 64'd1);
    chk("e_mresp_other", 64'(mresp[1]), 64'd0);
    cyc("e_err1");
    chk("e_no_handoff", 64'(grant), 64'b001);
    hready = 1'b1;
    cyc("e_err2");
    chk("e_handoff", 64'(grant), 64'b010);
    hresp = 1'b0;

    // Three continuous requesters rotate, then reset mid-sequence
    apply_reset("f");
    for (int m = 0; m < N; m++) set_m(m, 32'h7000 + 32'(m * 256), 2'd2);
    cyc("f_rst");
    resetn = 1'b1;
    cyc("f_park");
    chk("f_order0", 64'(grant), 64'(1 << order[0]));
    for (int k = 1; k < 4; k++) begin
      set_m(order[k-1], 32'h0, 2'd0);
      cyc("f_rot");
      chk("f_order", 64'(grant), 64'(1 << order[k]));
      set_m(order[k-1], 32'h7000 + 32'(order[k-1] * 256), 2'd2);
    end
    apply_reset("f_mid");
    cyc("f_in_rst");
    resetn = 1'b1;

    // Randomized traffic
    for (int c = 0; c < 400; c++) begin
      for (int m = 0; m < N; m++) set_m(m, $urandom, 2'($urandom));
      hready = ($urandom % 4) != 0;
      hresp  = ($urandom % 8) == 0;
      hrdata = $urandom;
      if ($urandom % 64 == 0) begin
        apply_reset("r");
        cyc("r_in_rst");
        resetn = 1'b1;
      end else begin
        cyc("rand");
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
